shift_reg_sequencer: RTL and testbench

Command-driven controller for the 8-bit load/shift register (`I`, `load_enable`, `shift_left_right`, `q`).
- Accepts a load-and-shift command over a valid/ready handshake.
- Sequences the register through one load cycle and N shift cycles.
- Emits each bit shifted out on a serial strobe, then returns the final register value over a result handshake.
- Sits between the register and its client logic and is the only block allowed to drive the register's control inputs.

---
 rtl/shift_reg_sequencer.sv | 82 ++++++++
 tb/tb_shift_reg_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// shift_reg_sequencer: load/shift command sequencer for an external WIDTH-bit load/shift register.
// Optional SHIFT_SEQ_ABORT_EN adds cmd_abort/res_aborted for early termination.
module shift_reg_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] reg_I,
  output logic             reg_load_enable,
  output logic             reg_dir,
  input  logic [WIDTH-1:0] reg_q,
  output logic             serial_valid,
  output logic             serial_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
`ifdef SHIFT_SEQ_ABORT_EN
  ,
  input  logic             cmd_abort,
  output logic             res_aborted
`endif
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt, count_q;
  logic [WIDTH-1:0] data_q;
  logic             dir_q, abort;
`ifdef SHIFT_SEQ_ABORT_EN
  logic             aborted;
  assign abort = cmd_abort;
  assign res_aborted = aborted;
  always_ff @(posedge clk or posedge reset)
    if (reset) aborted <= 1'b0;
    else aborted <= (state == LOAD || state == SHIFT) ? cmd_abort :
                    (state == DONE && !res_ready) ? aborted : 1'b0;
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      count_q <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          data_q  <= cmd_data;
          dir_q   <= cmd_dir;
          count_q <= cmd_count;
          state   <= LOAD;
        end
        LOAD: begin
          cnt   <= count_q;
          state <= (abort || count_q == '0) ? DONE : SHIFT;
        end
        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (abort || cnt == CNT_W'(1)) state <= DONE;
        end
        default: if (res_ready) state <= IDLE;
      endcase
    end
  // The register has no hold mode, so outside LOAD/SHIFT it reloads its own output.
  assign cmd_ready       = state == IDLE;
  assign busy            = state != IDLE;
  assign reg_load_enable = state == SHIFT;
  assign reg_I           = (state == LOAD) ? data_q : reg_q;
  assign reg_dir         = dir_q;
  assign serial_valid    = state == SHIFT;
  assign serial_out      = (state == SHIFT) & (dir_q ? reg_q[0] : reg_q[WIDTH-1]);
  assign res_valid       = state == DONE;
  assign res_data        = reg_q;
endmodule

// File: tb/tb_shift_reg_sequencer.sv
// tb_shift_reg_sequencer: scoreboard bench with a behavioural shift-register model and result/serial reference.
module tb_shift_reg_sequencer;
  logic clk = 0, reset = 0, cmd_valid = 0, cmd_dir = 0, res_ready = 0;
  logic [7:0] cmd_data = 0;
  logic [3:0] cmd_count = 0;
  logic [7:0] reg_I, reg_q, res_data;
  logic reg_load_enable, reg_dir, cmd_ready, serial_valid, serial_out, res_valid, busy, reset_n;
`ifdef SHIFT_SEQ_ABORT_EN
  logic cmd_abort = 0, res_aborted;
`endif
  int total = 0, bad = 0, cyc = 0, hs_cyc = -1, abort_cyc = -1;
  bit rr_rand = 0, res_prev = 0;
  typedef struct {logic [7:0] res; int due; logic ab;} exp_t;
  exp_t res_q[$];
  bit bit_q[$];

  shift_reg_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .reg_I(reg_I), .reg_load_enable(reg_load_enable), .reg_dir(reg_dir), .reg_q(reg_q),
    .serial_valid(serial_valid), .serial_out(serial_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
`ifdef SHIFT_SEQ_ABORT_EN
    , .cmd_abort(cmd_abort), .res_aborted(res_aborted)
`endif
  );

  // The controlled register: loads when load_enable=0, otherwise shifts in a zero.
  assign reset_n = ~reset;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) reg_q <= 8'h00;
    else if (!reg_load_enable) reg_q <= reg_I;
    else reg_q <= reg_dir ? {1'b0, reg_q[7:1]} : {reg_q[6:0], 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (rr_rand) res_ready = ($urandom_range(0, 3) != 0);
  end
`ifdef SHIFT_SEQ_ABORT_EN
  always @(posedge clk) begin
    #1;
    cmd_abort = (cyc == abort_cyc);
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic offer(input logic [7:0] d, input logic dir, input logic [3:0] cnt);
    cmd_data = d;
    cmd_dir = dir;
    cmd_count = cnt;
    cmd_valid = 1;
  endtask

  // Waits for the accept, pushes the reference expectation; a = abort cycle (0 = none).
  task automatic wait_accept(input int a, output int c);
    int n = 0, n_eff;
    exp_t e;
    logic [7:0] d;
    c = -1;
    while (n < 200) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
    end
    chk("accept_wait", n < 200, 1);
    if (n < 200) begin
      c = cyc;
      d = cmd_data;
      n_eff = (a == 0 || a - 1 > int'(cmd_count)) ? int'(cmd_count) : a - 1;
      for (int i = 0; i < n_eff; i++) begin
        if (i >= 8) bit_q.push_back(1'b0);
        else if (cmd_dir) bit_q.push_back(d[i]);
        else bit_q.push_back(d[7-i]);
      end
      e.res = cmd_dir ? d >> n_eff : d << n_eff;
      e.due = c + n_eff + 2;
      e.ab = (a != 0);
      res_q.push_back(e);
      abort_cyc = (a != 0) ? c + a : -1;
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask

  always @(negedge clk) begin
    if (serial_valid) begin
      chk("serial_pending", bit_q.size() != 0, 1);
      if (bit_q.size() != 0) chk("serial_out", serial_out, bit_q.pop_front());
    end
    if (res_valid) begin
      chk("res_pending", res_q.size() != 0, 1);
      chk("done_busy_ready", {busy, cmd_ready}, 2'b10);
      chk("done_hold", {reg_load_enable, reg_I}, {1'b0, reg_q});
      if (res_q.size() != 0) begin
        if (!res_prev) chk("res_latency", cyc, res_q[0].due);
        chk("res_data", res_data, res_q[0].res);
`ifdef SHIFT_SEQ_ABORT_EN
        chk("res_aborted", res_aborted, res_q[0].ab);
`endif
        if (res_ready) void'(res_q.pop_front());
      end
      if (res_ready) hs_cyc = cyc;
    end
    res_prev = res_valid;
  end

  initial begin
    int c, c2, n;
    #2 reset = 1;
    #1;
    chk("rst_ctrl", {cmd_ready, busy, res_valid, serial_valid, serial_out, reg_load_enable, reg_dir}, 7'b1000000);
    chk("rst_reg_I", reg_I, reg_q);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    rr_rand = 1;
    @(posedge clk);
    #1;
    offer(8'hA5, 0, 3); wait_accept(0, c);
    offer(8'hA5, 1, 2); wait_accept(0, c);
    offer(8'h3C, 0, 0); wait_accept(0, c);
    offer(8'hFF, 0, 9); wait_accept(0, c);
    // Backpressure: result held, next command offered but not accepted.
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    rr_rand = 0;
    res_ready = 0;
    offer(8'h81, 0, 1); wait_accept(0, c);
    offer(8'h55, 1, 2);
    n = 0;
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_res_valid", res_valid, 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_res_data", res_data, 8'h02);
    end
    @(posedge clk);
    #1 res_ready = 1;
    wait_accept(0, c2);
    chk("bp_accept_cycle", c2, hs_cyc + 1);
    rr_rand = 1;
    // Reset in cycle 3 of a count-6 command.
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    offer(8'hB7, 0, 6); wait_accept(0, c);
    while (cyc < c + 3) begin @(posedge clk); #1; end
    #2 reset = 1;
    res_q.delete();
    bit_q.delete();
    #1;
    chk("mid_rst_ctrl", {cmd_ready, busy, res_valid, serial_valid, serial_out, reg_load_enable, reg_dir}, 7'b1000000);
    chk("mid_rst_q", reg_q, 8'h00);
    chk("mid_rst_reg_I", reg_I, 8'h00);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    offer(8'h5A, 1, 3); wait_accept(0, c);
`ifdef SHIFT_SEQ_ABORT_EN
    offer(8'hF0, 0, 8); wait_accept(3, c);
`endif
    repeat (40) begin
      int a = 0;
      offer(8'($urandom), 1'($urandom), 4'($urandom));
`ifdef SHIFT_SEQ_ABORT_EN
      if (cmd_count != 0 && $urandom_range(0, 3) == 0) a = $urandom_range(1, int'(cmd_count));
`endif
      wait_accept(a, c);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
    end
    n = 0;
    while ((busy || res_q.size() != 0) && n < 500) begin @(posedge clk); #1; n++; end
    chk("drain", res_q.size() + bit_q.size(), 0);
    chk("final_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
